// File: rtl/fetch_sequencer.sv
// Fetch initiator: drives the PC onto program memory, waits for ready, strobes the IR load
// and then pulses the IR commit. Latched jumps replace the PC increment at the end of a fetch.
module fetch_sequencer #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              fault_clr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_oen,
  output logic              ir_loadn,
  output logic              ir_commit,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault
);

  localparam int unsigned WCNT_W = 8;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_LOAD   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_mem_oen;
  logic                r_ir_loadn;
  logic                r_ir_commit;
  logic                r_busy;
  logic                r_fault;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_jpend;
  logic [ADDR_W-1:0]   r_jaddr;

  state_t              w_state_n;
  logic [ADDR_W-1:0]   w_pc_n;
  logic                w_mem_oen_n;
  logic                w_ir_loadn_n;
  logic                w_ir_commit_n;
  logic                w_fault_n;
  logic [WCNT_W-1:0]   w_wcnt_n;
  logic                w_jpend_n;
  logic [ADDR_W-1:0]   w_jaddr_n;

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_VEC;
      r_mem_oen   <= 1'b1;
      r_ir_loadn  <= 1'b1;
      r_ir_commit <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
      r_wcnt      <= '0;
      r_jpend     <= 1'b0;
      r_jaddr     <= '0;
    end else begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_mem_oen   <= w_mem_oen_n;
      r_ir_loadn  <= w_ir_loadn_n;
      r_ir_commit <= w_ir_commit_n;
      r_busy      <= (w_state_n != S_IDLE);
      r_fault     <= w_fault_n;
      r_wcnt      <= w_wcnt_n;
      r_jpend     <= w_jpend_n;
      r_jaddr     <= w_jaddr_n;
    end
  end

  // Next-state and next-output logic; a timeout in the same cycle overrides fault_clr
  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_mem_oen_n   = r_mem_oen;
    w_ir_loadn_n  = 1'b1;
    w_ir_commit_n = 1'b0;
    w_fault_n     = r_fault & ~fault_clr;
    w_wcnt_n      = r_wcnt;
    w_jpend_n     = r_jpend;
    w_jaddr_n     = r_jaddr;

    if ((r_state != S_IDLE) && jump_en) begin
      w_jpend_n = 1'b1;
      w_jaddr_n = jump_addr;
    end

    case (r_state)
      S_IDLE: begin
        if (jump_en) begin
          w_pc_n = jump_addr;
        end else if (fetch_req && !r_fault) begin
          w_state_n   = S_ADDR;
          w_mem_oen_n = 1'b0;
          w_wcnt_n    = '0;
        end
      end
      S_ADDR: begin
        w_state_n = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          w_state_n    = S_LOAD;
          w_ir_loadn_n = 1'b0;
        end else if (r_wcnt == WCNT_LAST) begin
          w_state_n   = S_IDLE;
          w_fault_n   = 1'b1;
          w_mem_oen_n = 1'b1;
          w_jpend_n   = 1'b0;
        end else begin
          w_wcnt_n = r_wcnt + WCNT_W'(1);
        end
      end
      S_LOAD: begin
        w_state_n     = S_COMMIT;
        w_mem_oen_n   = 1'b1;
        w_ir_commit_n = 1'b1;
      end
      S_COMMIT: begin
        w_state_n = S_IDLE;
        w_jpend_n = 1'b0;
        if (jump_en) begin
          w_pc_n = jump_addr;
        end else if (r_jpend) begin
          w_pc_n = r_jaddr;
        end else begin
          w_pc_n = r_pc + ADDR_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign mem_addr  = r_pc;
  assign pc        = r_pc;
  assign mem_oen   = r_mem_oen;
  assign ir_loadn  = r_ir_loadn;
  assign ir_commit = r_ir_commit;
  assign busy      = r_busy;
  assign fault     = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a ROM model drives the bus, an IR model captures it,
// and each fetch's expected {address, data} is queued and retired on the commit pulse.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       fetch_req, jump_en, fault_clr, mem_ready;
  logic [7:0] jump_addr;
  logic [7:0] mem_addr, pc;
  logic       mem_oen, ir_loadn, ir_commit, busy, fault;

  logic [7:0]  bus;
  logic [7:0]  ir_q, ir_addr;
  logic [15:0] sb[$];
  logic [7:0]  exp_pc;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .resetn(resetn), .fetch_req(fetch_req), .jump_en(jump_en),
    .jump_addr(jump_addr), .fault_clr(fault_clr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_oen(mem_oen), .ir_loadn(ir_loadn), .ir_commit(ir_commit),
    .pc(pc), .busy(busy), .fault(fault)
  );

  function automatic logic [7:0] rom(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  assign bus = mem_oen ? 8'hzz : rom(mem_addr);

  always @(posedge clk) begin
    if (!ir_loadn) begin
      ir_q    <= bus;
      ir_addr <= mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Retire one queued fetch per commit pulse; the two strobes must never overlap
  always @(negedge clk) begin
    if (resetn && (!ir_loadn || ir_commit))
      chk("loadn_commit_excl", 32'(!ir_loadn && ir_commit), 32'd0);
    if (resetn && ir_commit) begin
      chk("commit_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [15:0] e;
        e = sb.pop_front();
        chk("ir_addr", 32'(ir_addr), 32'(e[15:8]));
        chk("ir_data", 32'(ir_q), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_fetch(input int dly, input int jmp_at, input logic [7:0] jmp_to,
                          input logic [7:0] next_pc, input bit hold);
    sb.push_back({exp_pc, rom(exp_pc)});
    fetch_req = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    if (!hold) fetch_req = 1'b0;
    chk("addr_busy", 32'(busy), 32'd1);
    chk("addr_oen", 32'(mem_oen), 32'd0);
    chk("addr_mem_addr", 32'(mem_addr), 32'(exp_pc));
    @(negedge clk);
    for (int i = 0; i < dly; i++) begin
      if (i == jmp_at) begin
        jump_en   = 1'b1;
        jump_addr = jmp_to;
      end else begin
        jump_en = 1'b0;
      end
      chk("wait_oen", 32'(mem_oen), 32'd0);
      chk("wait_loadn", 32'(ir_loadn), 32'd1);
      @(negedge clk);
    end
    jump_en   = 1'b0;
    chk("prewait_loadn", 32'(ir_loadn), 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("load_loadn", 32'(ir_loadn), 32'd0);
    chk("load_oen", 32'(mem_oen), 32'd0);
    @(negedge clk);
    chk("commit_pulse", 32'(ir_commit), 32'd1);
    chk("commit_loadn", 32'(ir_loadn), 32'd1);
    chk("commit_oen", 32'(mem_oen), 32'd1);
    @(negedge clk);
    chk("done_commit", 32'(ir_commit), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_pc", 32'(pc), 32'(next_pc));
    chk("done_fault", 32'(fault), 32'd0);
    exp_pc = next_pc;
  endtask

  initial begin
    resetn = 1'b0; fetch_req = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
    fault_clr = 1'b0; mem_ready = 1'b0; exp_pc = 8'h00;

    // reset state
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_oen", 32'(mem_oen), 32'd1);
    chk("rst_loadn", 32'(ir_loadn), 32'd1);
    chk("rst_commit", 32'(ir_commit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    resetn = 1'b1;

    // IDLE jump to 0x10, no fetch started
    jump_en = 1'b1; jump_addr = 8'h10;
    @(negedge clk);
    jump_en = 1'b0;
    chk("jmp_idle_pc", 32'(pc), 32'h10);
    chk("jmp_idle_busy", 32'(busy), 32'd0);
    exp_pc = 8'h10;

    // basic fetch, then wait states, then jump latched during WAIT
    do_fetch(0, -1, 8'h00, 8'h11, 1'b0);
    do_fetch(5, -1, 8'h00, 8'h12, 1'b0);
    do_fetch(3, 1, 8'h40, 8'h40, 1'b0);

    // IDLE jump beats fetch_req; fetch starts the following cycle at the jump target
    jump_en = 1'b1; jump_addr = 8'h50; fetch_req = 1'b1;
    @(negedge clk);
    jump_en = 1'b0;
    chk("jmp_wins_pc", 32'(pc), 32'h50);
    chk("jmp_wins_busy", 32'(busy), 32'd0);
    exp_pc = 8'h50;
    do_fetch(0, -1, 8'h00, 8'h51, 1'b0);

    // timeout: 15 WAIT cycles, latched jump discarded, fault_clr collides with timeout
    fetch_req = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      jump_en = (i == 2); jump_addr = 8'h77;
      chk("to_busy", 32'(busy), 32'd1);
      chk("to_loadn", 32'(ir_loadn), 32'd1);
      @(negedge clk);
    end
    jump_en = 1'b0;
    chk("to_last_fault", 32'(fault), 32'd0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_busy_done", 32'(busy), 32'd0);
    chk("to_oen", 32'(mem_oen), 32'd1);
    chk("to_pc", 32'(pc), 32'h51);

    // fault blocks fetches until cleared
    fetch_req = 1'b1;
    @(negedge clk);
    chk("blocked_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("blocked_busy1", 32'(busy), 32'd0);
    fetch_req = 1'b0; fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("fault_cleared", 32'(fault), 32'd0);
    do_fetch(1, -1, 8'h00, 8'h52, 1'b0);

    // wrap at 0xFF and back-to-back streaming
    jump_en = 1'b1; jump_addr = 8'hFF;
    @(negedge clk);
    jump_en = 1'b0;
    chk("wrap_setup_pc", 32'(pc), 32'hFF);
    exp_pc = 8'hFF;
    do_fetch(0, -1, 8'h00, 8'h00, 1'b1);
    do_fetch(0, -1, 8'h00, 8'h01, 1'b0);

    // reset mid-WAIT aborts with no commit
    fetch_req = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_oen", 32'(mem_oen), 32'd1);
    chk("midrst_loadn", 32'(ir_loadn), 32'd1);
    chk("midrst_pc", 32'(pc), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    resetn = 1'b1; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
